// File: rtl/fmul_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : fmul_result_checker
//  Purpose  : In-order checker for FP-multiplier results. Queues expected
//             values, compares each valid result against the queue head,
//             and keeps saturating pass/fail counters, a last-mismatch
//             capture, and sticky unexpected-result / timeout flags.
//  Revision : 1.0 - initial release
// ============================================================================
module fmul_result_checker #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int NAN_EQ  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       exp_valid,
    output logic                       exp_ready,
    input  logic [DATA_W-1:0]          exp_data,
    input  logic                       res_val,
    input  logic [DATA_W-1:0]          res_data,
    output logic [$clog2(DEPTH):0]     pending,
    output logic [15:0]                pass_cnt,
    output logic [15:0]                fail_cnt,
    output logic [DATA_W-1:0]          last_fail_exp,
    output logic [DATA_W-1:0]          last_fail_got,
    output logic                       unexp_err,
    output logic                       timeout_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_TMAX = c_CW'(TIMEOUT - 1);
    localparam logic [15:0]     c_SAT  = 16'hFFFF;
    localparam logic [c_AW:0]   c_ONE  = (c_AW + 1)'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // Expectation storage and pointers (one extra MSB distinguishes full/empty)
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;

    logic [15:0]       r_pass_cnt;
    logic [15:0]       r_fail_cnt;
    logic [DATA_W-1:0] r_last_exp;
    logic [DATA_W-1:0] r_last_got;
    logic              r_unexp_err;
    logic              r_timeout_err;
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [c_CW-1:0]   r_tcnt;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_drain;
    logic              w_match;
    logic [DATA_W-1:0] w_head;
    logic [c_AW:0]     w_pending;

    // fp32 NaN: all-ones exponent with a non-zero mantissa
    function automatic logic f_is_nan(input logic [DATA_W-1:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    // A push is refused when full even if a pop frees a slot this cycle
    assign w_push    = exp_valid && !w_full;
    // Empty is the start-of-cycle view, so a same-cycle first push cannot be popped
    assign w_pop     = res_val && !w_empty;
    assign w_pending = r_wr_ptr - r_rd_ptr;
    // This pop removes the last entry and nothing refills it
    assign w_drain   = w_pop && !w_push && (w_pending == c_ONE);
    assign w_head    = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_match   = (res_data == w_head) ||
                       ((NAN_EQ != 0) && f_is_nan(res_data) && f_is_nan(w_head));

    assign exp_ready     = !w_full;
    assign pending       = w_pending;
    assign pass_cnt      = r_pass_cnt;
    assign fail_cnt      = r_fail_cnt;
    assign last_fail_exp = r_last_exp;
    assign last_fail_got = r_last_got;
    assign unexp_err     = r_unexp_err;
    assign timeout_err   = r_timeout_err;

    // Expectation storage write; contents need no reset, pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= exp_data;
        end
    end

    // FIFO pointer advance on accepted push / pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ONE;
        end
    end

    // Scoreboard: counters, mismatch capture, unexpected-result flag; clr wins over a compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_last_exp  <= '0;
            r_last_got  <= '0;
            r_unexp_err <= 1'b0;
        end else if (clr) begin
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_last_exp  <= '0;
            r_last_got  <= '0;
            r_unexp_err <= 1'b0;
        end else begin
            if (w_pop) begin
                if (w_match) begin
                    if (r_pass_cnt != c_SAT) r_pass_cnt <= r_pass_cnt + 16'd1;
                end else begin
                    if (r_fail_cnt != c_SAT) r_fail_cnt <= r_fail_cnt + 16'd1;
                    r_last_exp <= w_head;
                    r_last_got <= res_data;
                end
            end
            if (res_val && w_empty) begin
                r_unexp_err <= 1'b1;
            end
        end
    end

    // Timeout FSM next state: waiting whenever expectations are outstanding
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty && !w_drain) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_empty || w_drain)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Timeout FSM state, idle-cycle counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (clr) begin
                r_tcnt        <= '0;
                r_timeout_err <= 1'b0;
            end else if (w_pop) begin
                r_tcnt <= '0;
            end else if (r_state == S_WAIT || !w_empty) begin
                // The first non-empty cycle counts even before the state catches up
                if (r_tcnt == c_TMAX) begin
                    r_timeout_err <= 1'b1;
                end else begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
            end else begin
                r_tcnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fmul_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fmul_result_checker
//  Purpose  : Directed self-checking bench for fmul_result_checker. Two
//             instances share stimulus: u_dut (NaN-equivalent compare) and
//             u_dut0 (bit-exact compare).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fmul_result_checker;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;
    logic              res_val;
    logic [DATA_W-1:0] res_data;

    logic              exp_ready,   exp_ready0;
    logic [3:0]        pending,     pending0;
    logic [15:0]       pass_cnt,    pass_cnt0;
    logic [15:0]       fail_cnt,    fail_cnt0;
    logic [DATA_W-1:0] lf_exp,      lf_exp0;
    logic [DATA_W-1:0] lf_got,      lf_got0;
    logic              unexp_err,   unexp_err0;
    logic              timeout_err, timeout_err0;

    int n_checks = 0;
    int n_pass   = 0;

    fmul_result_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(64), .NAN_EQ(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
        .res_val(res_val), .res_data(res_data), .pending(pending),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .last_fail_exp(lf_exp), .last_fail_got(lf_got),
        .unexp_err(unexp_err), .timeout_err(timeout_err)
    );

    fmul_result_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(64), .NAN_EQ(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .exp_valid(exp_valid), .exp_ready(exp_ready0), .exp_data(exp_data),
        .res_val(res_val), .res_data(res_data), .pending(pending0),
        .pass_cnt(pass_cnt0), .fail_cnt(fail_cnt0),
        .last_fail_exp(lf_exp0), .last_fail_got(lf_got0),
        .unexp_err(unexp_err0), .timeout_err(timeout_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; exp_valid = 1'b0; exp_data = '0;
        res_val = 1'b0; res_data = '0;
        repeat (3) tick();
        n_checks++;
        if ({pass_cnt, fail_cnt, lf_exp, lf_got} !== 96'd0)
            $display("FAIL reset_regs: got %h want 0", {pass_cnt, fail_cnt, lf_exp, lf_got});
        else n_pass++;
        n_checks++;
        if ({exp_ready, pending, unexp_err, timeout_err} !== 7'b1_0000_00)
            $display("FAIL reset_flags: got %b want 1000000", {exp_ready, pending, unexp_err, timeout_err});
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pass();
        exp_valid = 1'b1; exp_data = 32'h3F80_0000;
        tick();
        exp_valid = 1'b0;
        n_checks++;
        if (pending !== 4'd1) $display("FAIL pass_pending_push: got %0d want 1", pending);
        else n_pass++;
        tick(); tick();
        res_val = 1'b1; res_data = 32'h3F80_0000;
        tick();
        res_val = 1'b0;
        n_checks++;
        if ({pass_cnt, fail_cnt, pending} !== {16'd1, 16'd0, 4'd0})
            $display("FAIL pass_single: got pass=%0d fail=%0d pend=%0d want 1/0/0", pass_cnt, fail_cnt, pending);
        else n_pass++;
    endtask

    task automatic test_mismatch();
        exp_valid = 1'b1; exp_data = 32'h4000_0000;
        tick();
        exp_valid = 1'b0;
        res_val = 1'b1; res_data = 32'h4000_0001;
        tick();
        res_val = 1'b0;
        n_checks++;
        if ({pass_cnt, fail_cnt} !== {16'd1, 16'd1})
            $display("FAIL mismatch_cnt: got pass=%0d fail=%0d want 1/1", pass_cnt, fail_cnt);
        else n_pass++;
        n_checks++;
        if ({lf_exp, lf_got} !== {32'h4000_0000, 32'h4000_0001})
            $display("FAIL mismatch_capture: got %h/%h want 40000000/40000001", lf_exp, lf_got);
        else n_pass++;
    endtask

    task automatic test_nan();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if ({pass_cnt, fail_cnt, lf_exp, lf_got, unexp_err} !== 97'd0)
            $display("FAIL clr_zero: got pass=%0d fail=%0d exp=%h got=%h unexp=%b want 0",
                     pass_cnt, fail_cnt, lf_exp, lf_got, unexp_err);
        else n_pass++;
        exp_valid = 1'b1; exp_data = 32'h7FC0_0000;
        tick();
        exp_valid = 1'b0;
        res_val = 1'b1; res_data = 32'h7F80_0001;
        tick();
        res_val = 1'b0;
        n_checks++;
        if ({pass_cnt, fail_cnt} !== {16'd1, 16'd0})
            $display("FAIL nan_eq1: got pass=%0d fail=%0d want 1/0", pass_cnt, fail_cnt);
        else n_pass++;
        n_checks++;
        if ({pass_cnt0, fail_cnt0, lf_got0} !== {16'd0, 16'd1, 32'h7F80_0001})
            $display("FAIL nan_eq0: got pass=%0d fail=%0d got=%h want 0/1/7f800001", pass_cnt0, fail_cnt0, lf_got0);
        else n_pass++;
    endtask

    task automatic test_unexpected();
        exp_valid = 1'b1; exp_data = 32'h4040_0000;
        res_val = 1'b1; res_data = 32'h4040_0000;
        tick();
        exp_valid = 1'b0; res_val = 1'b0;
        n_checks++;
        if ({unexp_err, pass_cnt, fail_cnt, pending} !== {1'b1, 16'd1, 16'd0, 4'd1})
            $display("FAIL unexp_same_cycle: got unexp=%b pass=%0d fail=%0d pend=%0d want 1/1/0/1",
                     unexp_err, pass_cnt, fail_cnt, pending);
        else n_pass++;
        res_val = 1'b1;
        tick();
        res_val = 1'b0;
        n_checks++;
        if ({pass_cnt, pending, unexp_err} !== {16'd2, 4'd0, 1'b1})
            $display("FAIL unexp_drain: got pass=%0d pend=%0d unexp=%b want 2/0/1", pass_cnt, pending, unexp_err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp_valid = 1'b1; exp_data = 32'h4100_0000 + i;
            tick();
            if (i == 6) begin
                n_checks++;
                if (exp_ready !== 1'b1) $display("FAIL full_ready_7: got %b want 1", exp_ready);
                else n_pass++;
            end
            if (i == 7) begin
                n_checks++;
                if ({exp_ready, pending} !== {1'b0, 4'd8})
                    $display("FAIL full_after_8: got ready=%b pend=%0d want 0/8", exp_ready, pending);
                else n_pass++;
            end
        end
        exp_valid = 1'b0;
        n_checks++;
        if (pending !== 4'd8) $display("FAIL full_drop_9th: got pend=%0d want 8", pending);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            res_val = 1'b1; res_data = 32'h4100_0000 + i;
            tick();
        end
        res_val = 1'b0;
        n_checks++;
        if ({pass_cnt, fail_cnt, pending, exp_ready} !== {16'd8, 16'd0, 4'd0, 1'b1})
            $display("FAIL drain_in_order: got pass=%0d fail=%0d pend=%0d ready=%b want 8/0/0/1",
                     pass_cnt, fail_cnt, pending, exp_ready);
        else n_pass++;
    endtask

    task automatic test_timeout();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_valid = 1'b1; exp_data = 32'h3F80_0000;
        tick();
        exp_valid = 1'b0;
        repeat (63) tick();
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL timeout_early: got %b want 0 at 63 cycles", timeout_err);
        else n_pass++;
        tick();
        n_checks++;
        if (timeout_err !== 1'b1) $display("FAIL timeout_at_64: got %b want 1", timeout_err);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({exp_ready, pending, timeout_err, unexp_err, pass_cnt, fail_cnt} !== {1'b1, 4'd0, 2'b00, 32'd0})
            $display("FAIL async_reset: got ready=%b pend=%0d tout=%b unexp=%b pass=%0d fail=%0d want 1/0/0/0/0/0",
                     exp_ready, pending, timeout_err, unexp_err, pass_cnt, fail_cnt);
        else n_pass++;
        #1 rst_n = 1'b1;
        tick();
        res_val = 1'b1; res_data = 32'h3F80_0000;
        tick();
        res_val = 1'b0;
        n_checks++;
        if ({unexp_err, pass_cnt, pending} !== {1'b1, 16'd0, 4'd0})
            $display("FAIL reset_discard: got unexp=%b pass=%0d pend=%0d want 1/0/0", unexp_err, pass_cnt, pending);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_mismatch();
        test_nan();
        test_unexpected();
        test_back_to_back();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
